// File: rtl/sample_arb_pkg.sv
// sample_arb_pkg: shared definitions for the sample stream arbiter.
//   DROP_CNT_W : width of each per-channel saturating drop counter
//   MAX_CH     : largest supported channel count (sizes the arbiter helper)
//   next_rr()  : round-robin search returning the granted index plus a valid bit
package sample_arb_pkg;

    localparam int DROP_CNT_W = 16;
    localparam int MAX_CH     = 8;
    localparam int CH_IDX_W   = 3;

    typedef struct packed {
        logic                valid;
        logic [CH_IDX_W-1:0] idx;
    } rr_grant_t;

    // Searches last+1, last+2, ... (mod num_ch) and returns the first requester.
    // The search starts after 'last', so the previous winner has lowest priority.
    function automatic rr_grant_t next_rr(input logic [MAX_CH-1:0]   req,
                                          input logic [CH_IDX_W-1:0] last,
                                          input int                  num_ch);
        rr_grant_t g;
        int        k;
        g = '0;
        for (int i = 1; i <= MAX_CH; i++) begin
            if (i <= num_ch && !g.valid) begin
                k = (int'(last) + i) % num_ch;
                if (req[k]) begin
                    g.valid = 1'b1;
                    g.idx   = k[CH_IDX_W-1:0];
                end
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/sample_fifo2.sv
// sample_fifo2: 2-entry synchronous FIFO with show-ahead read data.
//   clk, rstn : clock, synchronous active-low reset
//   wr, wdata : push request and data; a push while full is accepted only
//               when rd pops the same cycle
//   rd        : pop request (caller only asserts it when not empty)
//   rdata     : current head, valid whenever empty=0
//   empty/full: occupancy flags
module sample_fifo2
    import sample_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  empty,
    output logic                  full
);

    logic [DATA_WIDTH-1:0] r_mem [2];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_count;
    logic                  w_push;
    logic                  w_pop;

    assign empty  = (r_count == 2'd0);
    assign full   = r_count[1];
    assign rdata  = r_mem[r_rd_ptr];
    assign w_pop  = rd && !empty;
    // When full, the slot being written is the one being popped this cycle.
    assign w_push = wr && (!full || w_pop);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage is not reset; the pointers/count define which entries are
    // meaningful, so clearing the data would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= wdata;
    end

endmodule

// File: rtl/sample_stream_arb.sv
// sample_stream_arb: merges NUM_CH non-backpressurable sample strobes onto one
// ready/valid stream with a channel tag, using per-channel 2-entry FIFOs and a
// round-robin arbiter feeding a single output register.
//   clk, rstn          : clock, synchronous active-low reset
//   en                 : capture enable (queued samples keep draining when 0)
//   in_data, in_valid  : packed per-channel samples and one-cycle strobes
//   m_data/m_chan/m_valid, m_ready : output stream
//   ovf, drop_cnt      : sticky overflow flags, saturating 16-bit drop counts
//   ovf_clr            : one-cycle clear of ovf and drop_cnt
module sample_stream_arb
    import sample_arb_pkg::*;
#(
    parameter  int NUM_CH     = 3,
    parameter  int DATA_WIDTH = 32,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         en,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]            in_valid,
    output logic [DATA_WIDTH-1:0]        m_data,
    output logic [CH_W-1:0]              m_chan,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [NUM_CH-1:0]            ovf,
    output logic [NUM_CH*DROP_CNT_W-1:0] drop_cnt,
    input  logic                         ovf_clr
);

    logic [NUM_CH-1:0]     w_wr;
    logic [NUM_CH-1:0]     w_rd;
    logic [NUM_CH-1:0]     w_empty;
    logic [NUM_CH-1:0]     w_full;
    logic [NUM_CH-1:0]     w_drop;
    logic [DATA_WIDTH-1:0] w_rdata [NUM_CH];

    logic                  w_load;
    rr_grant_t             w_rr;
    logic                  w_grant;
    logic [CH_W-1:0]       w_gnt_idx;
    logic [DATA_WIDTH-1:0] w_head;

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic [CH_W-1:0]       r_chan;
    logic [CH_W-1:0]       r_last;
    logic [NUM_CH-1:0]     r_ovf;
    logic [DROP_CNT_W-1:0] r_drop_cnt [NUM_CH];

    assign w_wr   = in_valid & {NUM_CH{en}};
    // A full FIFO only accepts a write when it is being popped the same cycle.
    assign w_drop = w_wr & w_full & ~w_rd;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        sample_fifo2 #(.DATA_WIDTH(DATA_WIDTH)) u_fifo (
            .clk   (clk),
            .rstn  (rstn),
            .wr    (w_wr[c]),
            .wdata (in_data[c*DATA_WIDTH +: DATA_WIDTH]),
            .rd    (w_rd[c]),
            .rdata (w_rdata[c]),
            .empty (w_empty[c]),
            .full  (w_full[c])
        );
        assign drop_cnt[c*DROP_CNT_W +: DROP_CNT_W] = r_drop_cnt[c];
    end

    // NOTE: every combinational output gets a default before any condition so
    // no path leaves it unassigned (which would infer a latch).
    always_comb begin
        w_load    = !r_valid || m_ready;
        w_rr      = next_rr(MAX_CH'(~w_empty), CH_IDX_W'(r_last), NUM_CH);
        w_grant   = w_load && w_rr.valid;
        w_gnt_idx = w_rr.idx[CH_W-1:0];
        w_rd      = '0;
        w_head    = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_grant && (w_gnt_idx == CH_W'(c))) begin
                w_rd[c] = 1'b1;
                w_head  = w_rdata[c];
            end
        end
    end

    // Output register: loads on empty or handshake, otherwise holds (stall).
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_chan  <= '0;
            r_last  <= CH_W'(NUM_CH - 1);
        end else if (w_load) begin
            if (w_grant) begin
                r_valid <= 1'b1;
                r_data  <= w_head;
                r_chan  <= w_gnt_idx;
                r_last  <= w_gnt_idx;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    // A drop coinciding with a clear is counted after the clear.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_ovf <= '0;
            for (int c = 0; c < NUM_CH; c++) r_drop_cnt[c] <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (ovf_clr) begin
                    r_ovf[c]      <= w_drop[c];
                    r_drop_cnt[c] <= w_drop[c] ? DROP_CNT_W'(1) : '0;
                end else if (w_drop[c]) begin
                    r_ovf[c] <= 1'b1;
                    if (r_drop_cnt[c] != '1) r_drop_cnt[c] <= r_drop_cnt[c] + DROP_CNT_W'(1);
                end
            end
        end
    end

    assign m_valid = r_valid;
    assign m_data  = r_data;
    assign m_chan  = r_chan;
    assign ovf     = r_ovf;

endmodule

// File: doc/sample_stream_arb.md
Name: sample_stream_arb

Overview:
Round-robin arbiter that merges NUM_CH free-running sample sources onto one ready/valid output stream, tagging each sample with its channel number. The sources are ADC-style streams, such as the file-driven sample readers, and they cannot be back-pressured. Each channel has a 2-entry holding FIFO to absorb collisions and downstream stalls. Overflow is reported per channel with sticky flags and saturating drop counters.

Parameters:
NUM_CH, 3, number of input channels (2..8)
DATA_WIDTH, 32, sample width in bits
CH_W, derived $clog2(NUM_CH) (min 1), width of channel tag; localparam, not overridable

Ports:
clk  in  1  system clock
rstn  in  1  synchronous reset, active-low
en  in  1  capture enable; 0 = ignore inputs, queued samples still drain
in_data  in  NUM_CH*DATA_WIDTH  channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH]
in_valid  in  NUM_CH  per-channel one-cycle sample strobe, no backpressure
m_data  out  DATA_WIDTH  output sample
m_chan  out  CH_W  channel of m_data
m_valid  out  1  output valid
m_ready  in  1  downstream ready
ovf  out  NUM_CH  sticky per-channel overflow flag
drop_cnt  out  NUM_CH*16  per-channel saturating drop count, channel c at [c*16 +: 16]
ovf_clr  in  1  one-cycle pulse; clears ovf and drop_cnt

Behaviour:
- Reset (rstn=0 at clk edge):
  - m_valid=0; m_data=0; m_chan=0; ovf=0; drop_cnt=0.
  - All FIFOs empty; last_grant=NUM_CH-1, so ch0 has first priority.
  - Reset mid-operation discards all queued and output-register samples with no drop counting.
- Capture:
  - Write channel c when in_valid[c] && en.
  - en=0 means no write and no drop count.
- FIFO full:
  - A write to a full FIFO with no same-cycle pop of that FIFO is dropped.
  - A drop sets ovf[c] and increments drop_cnt[c], saturating at 0xFFFF.
  - A write to a full FIFO with a same-cycle pop is accepted.
- Output register:
  - The output register loads when it is empty (m_valid=0) or when (m_valid && m_ready).
  - Grant goes to the first non-empty FIFO searching last_grant+1, +2, ... modulo NUM_CH.
  - On a grant: pop that FIFO; m_data/m_chan take its head; m_valid=1 next cycle; last_grant=granted channel.
  - If no FIFO is non-empty at a load opportunity, m_valid goes to 0 on handshake.
  - last_grant is unchanged when nothing is granted.
- AXI-stream rules:
  - While m_valid && !m_ready, m_data and m_chan are held stable.
  - m_valid never drops without a handshake, except on reset.
- Latency: in_valid at cycle k with the arbiter idle gives m_valid in cycle k+2. FIFO write happens at the end of k; grant and output load at the end of k+1.
- Throughput: one sample per clk when m_ready=1.
- Per-channel order is preserved.
- Storage per channel is 3 samples: 2 FIFO entries plus the output register when that channel holds it.
- ovf_clr:
  - Clears all ovf and drop_cnt.
  - If a drop on channel c coincides with ovf_clr: ovf[c]=1 and drop_cnt[c]=1.
- FIFO behaviour:
  - Each FIFO is 2 entries, with a 1-bit wr/rd pointer each and a 2-bit count.
  - Pointers wrap 1→0.
  - Simultaneous push+pop leaves the count unchanged. For a FIFO that is 1 entry full, the head is popped and the new sample becomes the head.

Decomposition:
- Package sample_arb_pkg:
  - localparam DROP_CNT_W=16.
  - Function next_rr(req, last) returning the granted index and a grant-valid bit.
- Sub-module sample_fifo2 (2-entry synchronous FIFO):
  - Ports clk, rstn, wr, wdata, rd, rdata, empty, full.
  - Instantiated NUM_CH times in a generate loop.
- Top level contains the arbiter, the output register and the overflow/counter logic.

Test Plan:
- Latency and order: ch0 in_valid every 4 clk, data 0x1,0x2,0x3, m_ready=1 → m_valid 2 cycles after each strobe, m_chan=0, data 0x1,0x2,0x3 in order, drop_cnt=0.
- Same-cycle arrival: ch0=0xA0, ch1=0xB1, ch2=0xC2 strobed together, m_ready=1 → (0,0xA0),(1,0xB1),(2,0xC2) on 3 consecutive cycles.
- Backpressure: m_ready=0, ch1 sends 0x11,0x12,0x13,0x14 → 0x14 dropped, ovf[1]=1, drop_cnt[1]=1, m_data=0x11 stable during stall; m_ready=1 → 0x11,0x12,0x13.
- Round-robin: ch0 and ch2 strobed every cycle, m_ready=1 → m_chan alternates 0,2,0,2; ch1 never appears; both drop counts increment; with ch1 also strobed every cycle, m_chan rotates 0,1,2,0.
- Saturation and clear: 65540 drops on ch2 → drop_cnt[2]=0xFFFF; ovf_clr alone → 0 and ovf[2]=0; ovf_clr coincident with a drop → drop_cnt[2]=1, ovf[2]=1.
- Reset and enable: rstn=0 with all FIFOs full and m_valid=1 → next cycle m_valid=0, counters 0; after release, simultaneous strobes grant ch0 first. en=0 with strobes on all channels → no output, no drops.
